// File: rtl/arbiter_rr_hold.sv
// arbiter_rr_hold: registered N-way arbiter. Fixed-priority or round-robin selection.
// The grant is held across a multi-cycle transaction and released on done, on the
// owner's request dropping, or when a hold timeout expires.
module arbiter_rr_hold #(
  parameter int unsigned REQ_WIDTH = 8,
  parameter int unsigned RR_MODE   = 1,
  parameter int unsigned MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_WIDTH-1:0]         req,
  input  logic                         done,
  output logic [REQ_WIDTH-1:0]         gnt,
  output logic                         gnt_vld,
  output logic [$clog2(REQ_WIDTH)-1:0] gnt_id,
  output logic                         timeout
);

  localparam int unsigned IW  = $clog2(REQ_WIDTH);
  localparam int unsigned CW  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [IW-1:0] LAST_ID = IW'(REQ_WIDTH - 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(LIM);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  state_e               state_q;
  logic [REQ_WIDTH-1:0] gnt_q;
  logic                 gnt_vld_q;
  logic [IW-1:0]        gnt_id_q;
  logic [IW-1:0]        ptr_q;
  logic                 timeout_q;
  logic [CW-1:0]        cnt_q;

  logic [REQ_WIDTH-1:0] cand;
  logic                 own_req;
  logic                 at_limit;
  logic                 rel;
  logic                 to_only;
  logic                 win_vld;
  logic [IW-1:0]        win_id;
  logic [IW-1:0]        ptr_d;
  logic [REQ_WIDTH-1:0] win_gnt;

  // Release decision for the current owner; the owner is excluded from re-arbitration
  always_comb begin
    own_req  = req[gnt_id_q];
    at_limit = (MAX_HOLD != 0) && (cnt_q == CNT_LIM);
    rel      = done || !own_req || at_limit;
    to_only  = at_limit && !done && own_req;
    cand     = (state_q == OWN) ? (req & ~gnt_q) : req;
  end

  // Winner selection: lowest index first, or upward from ptr with wrap-around
  always_comb begin
    int unsigned pos;
    win_vld = 1'b0;
    win_id  = '0;
    pos     = 0;
    for (int unsigned k = 0; k < REQ_WIDTH; k++) begin
      if (RR_MODE != 0) begin
        pos = 32'(ptr_q) + k;
        if (pos >= REQ_WIDTH) pos = pos - REQ_WIDTH;
      end else begin
        pos = k;
      end
      if (!win_vld && cand[IW'(pos)]) begin
        win_vld = 1'b1;
        win_id  = IW'(pos);
      end
    end
    ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
    win_gnt = {{(REQ_WIDTH-1){1'b0}}, 1'b1} << win_id;
  end

  // Ownership FSM with registered grant, pointer, hold counter and timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q   <= OWN;
            gnt_q     <= win_gnt;
            gnt_vld_q <= 1'b1;
            gnt_id_q  <= win_id;
            cnt_q     <= '0;
            if (RR_MODE != 0) ptr_q <= ptr_d;
          end
        end
        OWN: begin
          if (rel) begin
            timeout_q <= to_only;
            cnt_q     <= '0;
            if (win_vld) begin
              gnt_q     <= win_gnt;
              gnt_vld_q <= 1'b1;
              gnt_id_q  <= win_id;
              if (RR_MODE != 0) ptr_q <= ptr_d;
            end else begin
              state_q   <= IDLE;
              gnt_q     <= '0;
              gnt_vld_q <= 1'b0;
              gnt_id_q  <= '0;
            end
          end else if ((MAX_HOLD != 0) && (cnt_q != CNT_LIM)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_id  = gnt_id_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// tb_arbiter_rr_hold: scoreboard bench over four arbiter configurations.
module tb_arbiter_rr_hold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_u;
  logic [3:0] done_u;
  logic [7:0] req0;
  logic [3:0] req1;
  logic [3:0] req2;
  logic [4:0] req3;

  logic [7:0] g0;  logic v0;  logic [2:0] id0; logic to0;
  logic [3:0] g1;  logic v1;  logic [1:0] id1; logic to1;
  logic [3:0] g2;  logic v2;  logic [1:0] id2; logic to2;
  logic [4:0] g3;  logic v3;  logic [2:0] id3; logic to3;

  arbiter_rr_hold #(.REQ_WIDTH(8), .RR_MODE(1), .MAX_HOLD(16)) u_d8 (
    .clk(clk), .rst(rst_u[0]), .req(req0), .done(done_u[0]),
    .gnt(g0), .gnt_vld(v0), .gnt_id(id0), .timeout(to0));

  arbiter_rr_hold #(.REQ_WIDTH(4), .RR_MODE(0), .MAX_HOLD(16)) u_fx4 (
    .clk(clk), .rst(rst_u[1]), .req(req1), .done(done_u[1]),
    .gnt(g1), .gnt_vld(v1), .gnt_id(id1), .timeout(to1));

  arbiter_rr_hold #(.REQ_WIDTH(4), .RR_MODE(1), .MAX_HOLD(3)) u_rr4 (
    .clk(clk), .rst(rst_u[2]), .req(req2), .done(done_u[2]),
    .gnt(g2), .gnt_vld(v2), .gnt_id(id2), .timeout(to2));

  arbiter_rr_hold #(.REQ_WIDTH(5), .RR_MODE(1), .MAX_HOLD(0)) u_rr5 (
    .clk(clk), .rst(rst_u[3]), .req(req3), .done(done_u[3]),
    .gnt(g3), .gnt_vld(v3), .gnt_id(id3), .timeout(to3));

  typedef struct {
    int         unit;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int u, input logic [7:0] g, input logic [2:0] id,
                          input logic to, input string tag);
    exp_t e;
    e.unit = u; e.gnt = g; e.id = id; e.to = to; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Advance one clock, then retire every queued expectation against its unit
  task automatic tick();
    exp_t       e;
    logic [7:0] og;
    logic       ov;
    logic [2:0] oi;
    logic       ot;
    @(posedge clk);
    #1;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      case (e.unit)
        0:       begin og = g0;          ov = v0; oi = id0;         ot = to0; end
        1:       begin og = {4'b0, g1};  ov = v1; oi = {1'b0, id1}; ot = to1; end
        2:       begin og = {4'b0, g2};  ov = v2; oi = {1'b0, id2}; ot = to2; end
        default: begin og = {3'b0, g3};  ov = v3; oi = id3;         ot = to3; end
      endcase
      check_eq({e.tag, " gnt"},     32'(og), 32'(e.gnt));
      check_eq({e.tag, " gnt_vld"}, 32'(ov), 32'(e.gnt != 8'h0));
      check_eq({e.tag, " gnt_id"},  32'(oi), 32'(e.id));
      check_eq({e.tag, " timeout"}, 32'(ot), 32'(e.to));
    end
  endtask

  initial begin
    rst_u  = 4'hF;
    done_u = 4'h0;
    req0   = 8'hFF;
    req1   = '0;
    req2   = '0;
    req3   = '0;

    // Reset held two cycles with all requests active
    repeat (2) begin
      for (int u = 0; u < 4; u++) push_exp(u, 8'h00, 3'd0, 1'b0, "reset");
      tick();
    end
    rst_u = 4'h0;
    push_exp(0, 8'h01, 3'd0, 1'b0, "d8 first"); tick();
    req0 = 8'h00;
    push_exp(0, 8'h00, 3'd0, 1'b0, "d8 drop"); tick();

    // Fixed priority
    req1 = 4'b1010;
    push_exp(1, 8'h02, 3'd1, 1'b0, "fx 1010"); tick();
    done_u[1] = 1'b1;
    push_exp(1, 8'h08, 3'd3, 1'b0, "fx done"); tick();
    done_u[1] = 1'b0; req1 = 4'b1000;
    push_exp(1, 8'h08, 3'd3, 1'b0, "fx hold"); tick();
    req1 = 4'b0000;
    push_exp(1, 8'h00, 3'd0, 1'b0, "fx drop"); tick();
    req1 = 4'b0011;
    push_exp(1, 8'h01, 3'd0, 1'b0, "fx pair"); tick();
    done_u[1] = 1'b1;
    push_exp(1, 8'h02, 3'd1, 1'b0, "fx swap1"); tick();
    push_exp(1, 8'h01, 3'd0, 1'b0, "fx swap0"); tick();
    push_exp(1, 8'h02, 3'd1, 1'b0, "fx swap1b"); tick();
    done_u[1] = 1'b0; req1 = 4'b0000;
    push_exp(1, 8'h00, 3'd0, 1'b0, "fx idle"); tick();

    // Round-robin rotation with back-to-back handovers
    req2 = 4'hF; done_u[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_exp(2, 8'h01 << (i % 4), 3'(i % 4), 1'b0, "rr rot");
      tick();
    end
    done_u[2] = 1'b0; req2 = 4'h0;
    push_exp(2, 8'h00, 3'd0, 1'b0, "rr idle"); tick();

    // Hold timeout at MAX_HOLD=3 (ptr is 2 here, so index 0 wins first)
    req2 = 4'b0011;
    repeat (3) begin
      push_exp(2, 8'h01, 3'd0, 1'b0, "to hold"); tick();
    end
    push_exp(2, 8'h02, 3'd1, 1'b1, "to pulse"); tick();
    push_exp(2, 8'h02, 3'd1, 1'b0, "to after1"); tick();
    push_exp(2, 8'h02, 3'd1, 1'b0, "to after2"); tick();
    done_u[2] = 1'b1;
    push_exp(2, 8'h01, 3'd0, 1'b0, "limit+done"); tick();
    done_u[2] = 1'b0; req2 = 4'b0000;
    push_exp(2, 8'h00, 3'd0, 1'b0, "to idle"); tick();

    // Reset in the middle of ownership at the counter limit
    req2 = 4'b0100;
    repeat (3) begin
      push_exp(2, 8'h04, 3'd2, 1'b0, "own 0100"); tick();
    end
    rst_u[2] = 1'b1;
    push_exp(2, 8'h00, 3'd0, 1'b0, "rst mid"); tick();
    rst_u[2] = 1'b0; req2 = 4'b0110;
    push_exp(2, 8'h02, 3'd1, 1'b0, "post rst"); tick();
    req2 = 4'b0000;
    push_exp(2, 8'h00, 3'd0, 1'b0, "post rst idle"); tick();
    rst_u[2] = 1'b1;
    push_exp(2, 8'h00, 3'd0, 1'b0, "rst again"); tick();
    rst_u[2] = 1'b0; req2 = 4'b1001;
    push_exp(2, 8'h01, 3'd0, 1'b0, "ptr cleared"); tick();
    req2 = 4'b0000;
    push_exp(2, 8'h00, 3'd0, 1'b0, "rr4 end"); tick();

    // Non-power-of-2 wrap, timeout disabled
    req3 = 5'b10000;
    push_exp(3, 8'h10, 3'd4, 1'b0, "n5 top"); tick();
    req3 = 5'b10001; done_u[3] = 1'b1;
    push_exp(3, 8'h01, 3'd0, 1'b0, "n5 wrap0"); tick();
    push_exp(3, 8'h10, 3'd4, 1'b0, "n5 back4"); tick();
    done_u[3] = 1'b0; req3 = 5'b10000;
    repeat (20) begin
      push_exp(3, 8'h10, 3'd4, 1'b0, "n5 no limit"); tick();
    end
    req3 = 5'b00000;
    push_exp(3, 8'h00, 3'd0, 1'b0, "n5 drop"); tick();
    done_u[3] = 1'b1;
    push_exp(3, 8'h00, 3'd0, 1'b0, "n5 done idle"); tick();
    req3 = 5'b00100;
    push_exp(3, 8'h04, 3'd2, 1'b0, "n5 done ignored"); tick();
    push_exp(3, 8'h00, 3'd0, 1'b0, "n5 min own"); tick();
    done_u[3] = 1'b0; req3 = 5'b00000;
    push_exp(3, 8'h00, 3'd0, 1'b0, "n5 end"); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
